// File: rtl/switch_input_port.sv
// Switch ingress port. Buffers one whole packet from the byte-serial input,
// decodes the destination from byte 0, then forwards the packet over a valid/ready stream.
module switch_input_port #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_in,
  input  logic                 sw_enable_in,
  output logic                 read_out,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [NUM_PORTS-1:0] out_port,
  output logic                 pkt_err,
  output logic [15:0]          pkt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

  typedef enum logic [1:0] {IDLE, RECV, SEND, OVF} state_t;

  state_t        state;
  logic          en_q;
  logic          start;
  logic [LW-1:0] len;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    pkt_buf [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign start = sw_enable_in & ~en_q;

  // Byte 0 goes to address 0 on the rising edge; later bytes land at the current length.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (state == IDLE && start) begin
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (state == RECV && sw_enable_in && len != LW'(DEPTH)) begin
      wr_en   = 1'b1;
      wr_addr = len[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pkt_buf[wr_addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      len       <= '0;
      rd_ptr    <= '0;
      read_out  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_port  <= '0;
      pkt_err   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      en_q    <= sw_enable_in;
      pkt_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len   <= LW'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (sw_enable_in) begin
            if (len == LW'(DEPTH)) begin
              state    <= OVF;
              pkt_err  <= 1'b1;
              read_out <= 1'b1;
            end else begin
              len <= len + LW'(1);
            end
          end else if (len < LW'(3)) begin
            pkt_err <= 1'b1;
            len     <= '0;
            state   <= IDLE;
          end else begin
            out_port  <= PORT_ONE << pkt_buf[0][PW-1:0];
            out_data  <= pkt_buf[0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            rd_ptr    <= '0;
            read_out  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (start) pkt_err <= 1'b1;
          // out_valid is always high here, so out_ready alone is the handshake.
          if (out_ready) begin
            if (out_last) begin
              pkt_cnt   <= pkt_cnt + 16'd1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_port  <= '0;
              read_out  <= 1'b0;
              len       <= '0;
              state     <= IDLE;
            end else begin
              rd_ptr   <= rd_ptr + AW'(1);
              out_data <= pkt_buf[rd_ptr + AW'(1)];
              out_last <= (LW'(rd_ptr) + LW'(2) == len);
            end
          end
        end
        OVF: begin
          if (start) pkt_err <= 1'b1;
          if (!sw_enable_in) begin
            len      <= '0;
            read_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Scoreboard bench for switch_input_port: directed packets push expected bytes,
// a negedge monitor pops and compares on every output handshake.
module tb_switch_input_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] out_port;
  logic       pkt_err;
  logic [15:0] pkt_cnt;

  switch_input_port #(.DEPTH(32), .NUM_PORTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sw_enable_in(sw_enable_in),
    .read_out(read_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_port(out_port),
    .pkt_err(pkt_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
    logic [3:0] port;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         err_cnt = 0;
  int         hs_total = 0;
  int         ro_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_err = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: scoreboard compare, stall hold, pkt_err width and busy-cycle count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_out) ro_cycles++;
      if (pkt_err) begin
        err_cnt++;
        if (prev_err) check("pkt_err_width", 2, 1);
      end
      if (prev_stall) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_data_held", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        hs_total++;
        if (sb.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", int'(out_data), int'(e.data));
          check("out_last", int'(out_last), int'(e.last));
          check("out_port", int'(out_port), int'(e.port));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = pkt_err;
    end else begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end
  end

  task automatic expect_stim(input logic [3:0] port);
    for (int i = 0; i < stim.size(); i++) begin
      exp_t e;
      e.data = stim[i];
      e.last = (i == stim.size() - 1);
      e.port = port;
      sb.push_back(e);
    end
  endtask

  task automatic drive_stim();
    for (int i = 0; i < stim.size(); i++) begin
      data_in      = stim[i];
      sw_enable_in = 1'b1;
      @(posedge clk); #1;
    end
    sw_enable_in = 1'b0;
    data_in      = '0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || read_out || out_valid) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) check({name, "_timeout"}, n, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int n;
    rst_n = 1'b0; data_in = '0; sw_enable_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_out", int'(read_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_port", int'(out_port), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_pkt_err", int'(pkt_err), 0);
    check("rst_pkt_cnt", int'(pkt_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 5-byte packet to port 2, no backpressure
    ro_cycles = 0; e0 = err_cnt;
    stim = '{8'h02, 8'h11, 8'hA0, 8'hA1, 8'hA2};
    expect_stim(4'b0100);
    drive_stim();
    check("busy_before_send", int'(read_out), 0);
    @(posedge clk); #1;
    check("first_valid_latency", int'(out_valid), 1);
    check("first_byte", int'(out_data), 8'h02);
    check("read_out_rise", int'(read_out), 1);
    wait_drain("basic", 50);
    check("basic_busy_cycles", ro_cycles, 5);
    check("basic_pkt_cnt", int'(pkt_cnt), 1);
    check("basic_no_err", err_cnt - e0, 0);

    // same packet with out_ready pattern 1,0,0 repeating
    e0 = hs_total;
    expect_stim(4'b0100);
    fork
      drive_stim();
      begin
        for (int k = 0; k < 60; k++) begin
          out_ready = (k % 3 == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("bp", 50);
    check("bp_handshakes", hs_total - e0, 5);
    check("bp_pkt_cnt", int'(pkt_cnt), 2);

    // short packet: 2 bytes
    ro_cycles = 0; e0 = err_cnt;
    stim = '{8'h01, 8'h22};
    drive_stim();
    @(posedge clk); #1;
    check("short_err_pulse", int'(pkt_err), 1);
    @(posedge clk); #1;
    check("short_err_end", int'(pkt_err), 0);
    wait_drain("short", 20);
    check("short_err_count", err_cnt - e0, 1);
    check("short_busy_cycles", ro_cycles, 0);
    check("short_pkt_cnt", int'(pkt_cnt), 2);

    // overflow: 33 bytes
    e0 = err_cnt;
    for (int i = 0; i < 33; i++) begin
      data_in = 8'(i); sw_enable_in = 1'b1;
      @(posedge clk); #1;
      if (i == 31) check("ovf_not_yet", int'(read_out), 0);
      if (i == 32) begin
        check("ovf_err_pulse", int'(pkt_err), 1);
        check("ovf_busy", int'(read_out), 1);
      end
    end
    @(posedge clk); #1;
    check("ovf_busy_hold", int'(read_out), 1);
    sw_enable_in = 1'b0;
    @(posedge clk); #1;
    check("ovf_release", int'(read_out), 0);
    check("ovf_err_count", err_cnt - e0, 1);
    stim = '{8'h05, 8'h33, 8'h44};
    expect_stim(4'b0010);
    drive_stim();
    wait_drain("post_ovf", 50);
    check("post_ovf_pkt_cnt", int'(pkt_cnt), 3);

    // busy collision: second packet starts while first is in SEND
    out_ready = 1'b0;
    stim = '{8'h00, 8'hAA, 8'hBB};
    expect_stim(4'b0001);
    drive_stim();
    repeat (3) @(posedge clk);
    #1;
    check("coll_in_send", int'(read_out), 1);
    e0 = err_cnt;
    stim = '{8'h01, 8'hCC, 8'hDD};
    drive_stim();
    out_ready = 1'b1;
    wait_drain("coll", 50);
    repeat (5) @(posedge clk);
    #1;
    check("coll_err_count", err_cnt - e0, 1);
    check("coll_pkt_cnt", int'(pkt_cnt), 4);
    check("coll_idle_valid", int'(out_valid), 0);

    // reset while sending
    stim = '{8'h02, 8'h11, 8'hA0, 8'hA1, 8'hA2};
    expect_stim(4'b0100);
    e0 = hs_total;
    drive_stim();
    n = 0;
    while (hs_total - e0 < 2 && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 30) check("rst_mid_timeout", n, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_read_out", int'(read_out), 0);
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_out_port", int'(out_port), 0);
    check("rstmid_out_data", int'(out_data), 0);
    check("rstmid_out_last", int'(out_last), 0);
    check("rstmid_pkt_cnt", int'(pkt_cnt), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim = '{8'h03, 8'h12, 8'h34};
    expect_stim(4'b1000);
    drive_stim();
    @(posedge clk); #1;
    check("rstmid_new_port", int'(out_port), 4'b1000);
    wait_drain("post_rst", 50);
    check("post_rst_pkt_cnt", int'(pkt_cnt), 1);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
